// File: rtl/clint_arbiter.sv
// Two-master arbiter in front of the CLINT register block: round-robin with lock,
// plus a read tag pipeline that routes returning read data to the issuing master.
module clint_arbiter #(
  parameter int RD_LATENCY     = 1,
  parameter int ADDR_WIDTH     = 32,
  parameter int SIZE_WIDTH     = 4,
  parameter int REG_DATA_WIDTH = 32,
  parameter int BUS_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m0_req,
  input  logic                      m0_we,
  input  logic                      m0_lock,
  input  logic [ADDR_WIDTH-1:0]     m0_addr,
  input  logic [SIZE_WIDTH-1:0]     m0_size,
  input  logic [REG_DATA_WIDTH-1:0] m0_wdata,
  output logic                      m0_gnt,
  output logic                      m0_rvalid,
  output logic [BUS_DATA_WIDTH-1:0] m0_rdata,
  input  logic                      m1_req,
  input  logic                      m1_we,
  input  logic                      m1_lock,
  input  logic [ADDR_WIDTH-1:0]     m1_addr,
  input  logic [SIZE_WIDTH-1:0]     m1_size,
  input  logic [REG_DATA_WIDTH-1:0] m1_wdata,
  output logic                      m1_gnt,
  output logic                      m1_rvalid,
  output logic [BUS_DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0]     bus_clint_read_addr,
  output logic [SIZE_WIDTH-1:0]     bus_clint_read_size,
  output logic [ADDR_WIDTH-1:0]     bus_clint_write_addr,
  output logic [SIZE_WIDTH-1:0]     bus_clint_write_size,
  output logic [REG_DATA_WIDTH-1:0] bus_clint_data,
  output logic                      bus_clint_rd,
  output logic                      bus_clint_wr,
  input  logic [BUS_DATA_WIDTH-1:0] clint_bus_data,
  output logic [2:0]                dbg_state_o
);

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("clint_arbiter: RD_LATENCY must be in 1..4");
  end

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e                    state_q;
  logic                      owner_q;
  logic                      rr_q;
  logic [RD_LATENCY-1:0]     tag_v_q;
  logic [RD_LATENCY-1:0]     tag_id_q;
  logic                      rvalid0_q, rvalid1_q;
  logic [BUS_DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  logic                      gnt0_d, gnt1_d, gnt_any, sel;
  logic                      g_we, g_lock;
  logic [ADDR_WIDTH-1:0]     g_addr;
  logic [SIZE_WIDTH-1:0]     g_size;
  logic [REG_DATA_WIDTH-1:0] g_wdata;

  // Grant is combinational; reset masks it so nothing reaches the bus while rst=1.
  always_comb begin
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    if (!rst) begin
      if (state_q == LOCKED) begin
        gnt0_d = m0_req & ~owner_q;
        gnt1_d = m1_req &  owner_q;
      end else if (m0_req && m1_req) begin
        gnt0_d = ~rr_q;
        gnt1_d =  rr_q;
      end else begin
        gnt0_d = m0_req;
        gnt1_d = m1_req;
      end
    end
  end

  assign gnt_any = gnt0_d | gnt1_d;
  assign sel     = gnt1_d;
  assign g_we    = sel ? m1_we    : m0_we;
  assign g_lock  = sel ? m1_lock  : m0_lock;
  assign g_addr  = sel ? m1_addr  : m0_addr;
  assign g_size  = sel ? m1_size  : m0_size;
  assign g_wdata = sel ? m1_wdata : m0_wdata;

  assign m0_gnt               = gnt0_d;
  assign m1_gnt               = gnt1_d;
  assign bus_clint_rd         = gnt_any & ~g_we;
  assign bus_clint_wr         = gnt_any &  g_we;
  assign bus_clint_read_addr  = gnt_any ? g_addr  : '0;
  assign bus_clint_write_addr = gnt_any ? g_addr  : '0;
  assign bus_clint_read_size  = gnt_any ? g_size  : '0;
  assign bus_clint_write_size = gnt_any ? g_size  : '0;
  assign bus_clint_data       = gnt_any ? g_wdata : '0;

  assign m0_rvalid   = rvalid0_q;
  assign m1_rvalid   = rvalid1_q;
  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;
  assign dbg_state_o = {state_q == LOCKED, owner_q, rr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      tag_v_q   <= '0;
      tag_id_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            rr_q <= ~sel;
            if (g_lock) begin
              state_q <= LOCKED;
              owner_q <= sel;
            end
          end
        end
        LOCKED: begin
          if (gnt_any && !g_lock) begin
            state_q <= IDLE;
            rr_q    <= ~owner_q;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Tag of each granted read travels alongside the downstream latency.
      tag_v_q[0]  <= bus_clint_rd;
      tag_id_q[0] <= sel;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end

      rvalid0_q <= tag_v_q[RD_LATENCY-1] & ~tag_id_q[RD_LATENCY-1];
      rvalid1_q <= tag_v_q[RD_LATENCY-1] &  tag_id_q[RD_LATENCY-1];
      if (tag_v_q[RD_LATENCY-1] && !tag_id_q[RD_LATENCY-1]) rdata0_q <= clint_bus_data;
      if (tag_v_q[RD_LATENCY-1] &&  tag_id_q[RD_LATENCY-1]) rdata1_q <= clint_bus_data;
    end
  end

endmodule

// File: doc/clint_arbiter.md
CLINT_ARBITER -- requirements
Module: clint_arbiter

Interface
REQ-001 Parameter RD_LATENCY, default 1, meaning cycles from a granted read beat to its data on clint_bus_data; legal range 1..4.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 mN_req  in  1  (N=0,1) beat request; held stable with all mN_ payload until mN_gnt.
REQ-005 mN_we  in  1  1 = write beat, 0 = read beat.
REQ-006 mN_lock  in  1  keep grant on this master after this beat.
REQ-007 mN_addr  in  ADDR_WIDTH  beat address.
REQ-008 mN_size  in  SIZE_WIDTH  beat size in bytes.
REQ-009 mN_wdata  in  REG_DATA_WIDTH  write data.
REQ-010 mN_gnt  out  1  beat accepted this cycle, combinational.
REQ-011 mN_rvalid  out  1  read data valid pulse, registered.
REQ-012 mN_rdata  out  BUS_DATA_WIDTH  read data, registered, held between pulses.
REQ-013 bus_clint_read_addr / bus_clint_write_addr  out  ADDR_WIDTH  downstream addresses.
REQ-014 bus_clint_read_size / bus_clint_write_size  out  SIZE_WIDTH  downstream sizes.
REQ-015 bus_clint_data  out  REG_DATA_WIDTH  downstream write data.
REQ-016 bus_clint_rd / bus_clint_wr  out  1  downstream read / write strobes.
REQ-017 clint_bus_data  in  BUS_DATA_WIDTH  downstream read data, valid RD_LATENCY cycles after bus_clint_rd.

Function
REQ-018 At most one beat is granted per cycle; mN_gnt is asserted only if mN_req=1 and rst=0.
REQ-019 Granted beat drives bus_clint_rd = ~we or bus_clint_wr = we, exactly one for one cycle; both strobes are 0 when no grant.
REQ-020 Read and write addr/size buses carry the granted master's addr/size; bus_clint_data carries its wdata; all four carry 0 when no grant.
REQ-021 State machine: states IDLE and LOCKED; state register plus owner bit plus round-robin pointer rr.
REQ-022 In IDLE with one requester, that requester is granted; with both, master rr is granted.
REQ-023 After any IDLE grant, rr is set to the other master.
REQ-024 In IDLE, a granted beat with lock=1 moves to LOCKED with owner = granted master.
REQ-025 In LOCKED, only owner is granted; the other master waits even if owner's req=0.
REQ-026 In LOCKED, an owner beat granted with lock=0 returns to IDLE; rr is set to the non-owner.
REQ-027 A read tag pipeline RD_LATENCY deep carries (valid, master id) per granted read; reads are fully pipelined, one per cycle, with no stall on outstanding reads.
REQ-028 When the tag exits with valid=1, in that same cycle the arbiter samples clint_bus_data into mID_rdata and pulses mID_rvalid for one cycle, so rvalid appears RD_LATENCY+1 cycles after the read grant.
REQ-029 Response order equals grant order; a write granted in the same cycle a read response returns is permitted.
REQ-030 Writes produce no response; a write is complete on its grant cycle.

Reset
REQ-031 On rst=1 at posedge clk: state=IDLE, rr=0, owner=0, all tag valids=0, mN_rvalid=0, mN_rdata=0.
REQ-032 While rst=1, mN_gnt=0 and bus_clint_rd=bus_clint_wr=0 combinationally.
REQ-033 Reads in flight when reset is asserted are discarded and never produce rvalid.
REQ-034 The first cycle after reset deassertion is IDLE with rr=0.

Verification
REQ-035 Scenario 1: after reset, both masters request reads on consecutive cycles -> grants m0, m1, m0, m1 alternate; rvalid returns to each master in grant order, RD_LATENCY+1 cycles after each grant.
REQ-036 Scenario 2: m0 writes addr 0x4000, lock=1, then 0x4004, lock=0; m1 requests throughout -> m1 is granted only after the 0x4004 beat; bus_clint_wr=1 with size 4 on both beats.
REQ-037 Scenario 3: m1 reads 0xbff8 with RD_LATENCY=1; stub returns 0x12345678 -> m1_rvalid pulses once with m1_rdata=0x12345678; m0_rvalid stays 0.
REQ-038 Scenario 4: m0 read granted, rst asserted the next cycle for 1 cycle -> no rvalid ever appears; the first grant after reset goes to m0 when both request.
REQ-039 Scenario 5: LOCKED owner m0 with req=0 for 3 cycles while m1 requests -> no grants occur and both strobes stay 0 until m0 issues a lock=0 beat.
REQ-040 Scenario 6: m0 read and m1 write granted back-to-back with RD_LATENCY=2 -> the write strobe appears during the read's pending cycles, and m0_rvalid appears 3 cycles after its grant.
